// File: rtl/uart_pkg.sv
// Shared definitions for the DRAM-to-PC UART transmitter.
//   uart_state_e      : transmitter FSM state encoding
//   UART_DATA_BITS    : data bits per UART frame
//   DRAM_READ_LATENCY : cycles from a DRAM address change to a valid q
//   UART_IDLE_LEVEL   : level of the TX line between frames
//   even_parity()     : XOR of the data bits, used when UART_TX_PARITY_EN is defined
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    PARITY,
    STOP,
    NEXT,
    DONE
  } uart_state_e;

  localparam int   UART_DATA_BITS    = 8;
  localparam int   DRAM_READ_LATENCY = 2;
  localparam logic UART_IDLE_LEVEL   = 1'b1;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 and pulses tick for one cycle on the last count,
// then wraps to 0 so every bit period is exactly CLKS_PER_BIT cycles.
// Ports:
//   clk   : divided system clock
//   rst   : synchronous, active-high reset
//   clear : holds the count at 0 (used while no bit is being driven)
//   tick  : one-cycle pulse marking the last cycle of a bit period
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned      CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] baud_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      baud_cnt <= '0;
    end else if (baud_cnt == LAST) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

  assign tick = (baud_cnt == LAST) && !clear;

endmodule

// File: rtl/dram_uart_transmitter.sv
// Reads NUM_BYTES result bytes from data memory starting at START_ADDR and
// sends each one to the PC as a UART frame (start, 8 data bits LSB first,
// stop). A 3-cycle high gap separates bytes (one NEXT cycle plus the DRAM
// fetch). Completion is held on end_transmitting until begin_transmit drops,
// so a switch left high cannot trigger a second run.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11 bit periods per frame).
// Ports:
//   clk              : divided system clock
//   rst              : synchronous, active-high reset
//   begin_transmit   : debounced request level, sampled in IDLE
//   mem_data         : DRAM q, valid DRAM_READ_LATENCY cycles after mem_addr changes
//   mem_addr         : DRAM read address
//   tx_active        : high while this block owns the DRAM address port
//   data_to_pc       : UART TX line, idle high
//   end_transmitting : high while in DONE
module dram_uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned       CLKS_PER_BIT = 434,
  parameter int unsigned       ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] START_ADDR   = '0,
  parameter logic [15:0]       NUM_BYTES    = 16'd9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              begin_transmit,
  input  logic [7:0]        mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              tx_active,
  output logic              data_to_pc,
  output logic              end_transmitting
);

  localparam logic [1:0] FETCH_LAST = 2'(DRAM_READ_LATENCY - 1);
  localparam logic [2:0] LAST_BIT   = 3'(UART_DATA_BITS - 1);

  uart_state_e               state;
  logic [1:0]                fetch_cnt;
  logic [2:0]                bit_cnt;
  logic [15:0]               byte_cnt;
  logic [UART_DATA_BITS-1:0] shift_reg;
`ifdef UART_TX_PARITY_EN
  logic                      parity_bit;
`endif

  logic baud_clear;
  logic tick;

  // The bit timer only runs while a bit is on the line; everywhere else it
  // is held at 0 so the first bit of a frame gets a full period.
  assign baud_clear = !(state inside {START, DATA, PARITY, STOP});

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (tick)
  );

  // NOTE: every register here, outputs included, uses non-blocking
  // assignment so all of them see the pre-edge values of each other.
  // data_to_pc is loaded with the level of the state being entered, so the
  // line comes straight from a flop and each level lasts exactly as long as
  // its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      data_to_pc       <= UART_IDLE_LEVEL;
      mem_addr         <= START_ADDR;
      tx_active        <= 1'b0;
      end_transmitting <= 1'b0;
      fetch_cnt        <= '0;
      bit_cnt          <= '0;
      byte_cnt         <= '0;
      shift_reg        <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (begin_transmit) begin
            mem_addr  <= START_ADDR;
            byte_cnt  <= '0;
            tx_active <= 1'b1;
            fetch_cnt <= '0;
            state     <= FETCH;
          end
        end

        // Wait out the DRAM read latency; q is sampled only on the last cycle.
        FETCH: begin
          if (fetch_cnt == FETCH_LAST) begin
            shift_reg  <= mem_data;
`ifdef UART_TX_PARITY_EN
            parity_bit <= even_parity(mem_data);
`endif
            bit_cnt    <= '0;
            fetch_cnt  <= '0;
            data_to_pc <= 1'b0;
            state      <= START;
          end else begin
            fetch_cnt <= fetch_cnt + 2'd1;
          end
        end

        START: begin
          if (tick) begin
            data_to_pc <= shift_reg[0];
            state      <= DATA;
          end
        end

        // shift_reg[0] is on the line; shifting right brings up the next bit.
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              data_to_pc <= parity_bit;
              state      <= PARITY;
`else
              data_to_pc <= UART_IDLE_LEVEL;
              state      <= STOP;
`endif
            end else begin
              data_to_pc <= shift_reg[1];
              shift_reg  <= {1'b0, shift_reg[UART_DATA_BITS-1:1]};
              bit_cnt    <= bit_cnt + 3'd1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            data_to_pc <= UART_IDLE_LEVEL;
            state      <= STOP;
          end
        end
`endif

        STOP: begin
          if (tick) begin
            state <= NEXT;
          end
        end

        NEXT: begin
          if (byte_cnt == NUM_BYTES - 16'd1) begin
            end_transmitting <= 1'b1;
            tx_active        <= 1'b0;
            state            <= DONE;
          end else begin
            byte_cnt  <= byte_cnt + 16'd1;
            mem_addr  <= mem_addr + ADDR_W'(1);
            fetch_cnt <= '0;
            state     <= FETCH;
          end
        end

        // Hold completion until the request is released.
        DONE: begin
          data_to_pc <= UART_IDLE_LEVEL;
          if (!begin_transmit) begin
            end_transmitting <= 1'b0;
            state            <= IDLE;
          end
        end

        default: begin
          data_to_pc <= UART_IDLE_LEVEL;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_uart_transmitter.sv
// Self-checking bench for dram_uart_transmitter.
// The reference model is the frame definition itself: for every byte read
// from the bench DRAM it builds the expected line level for each cycle
// (start 0, data LSB first, optional even parity, stop 1, 3-cycle gap) and
// decodes the byte from mid-bit samples. Honours UART_TX_PARITY_EN.
module tb_dram_uart_transmitter;

  localparam int          CPB       = 4;
  localparam int          NB        = 3;
  localparam logic [15:0] SA        = 16'hFFFE;
`ifdef UART_TX_PARITY_EN
  localparam int          BPF       = 11;
`else
  localparam int          BPF       = 10;
`endif
  localparam int          GAP       = 3;
  localparam int          START_LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        begin_transmit;
  logic [7:0]  mem_data;
  logic [15:0] mem_addr;
  logic        tx_active;
  logic        data_to_pc;
  logic        end_transmitting;

  logic [7:0]  dram [0:65535];
  logic [15:0] addr_q;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // DRAM model: address registered on the clock, q read from the registered
  // address, so q is valid in the second cycle after mem_addr changes.
  always @(posedge clk) addr_q <= mem_addr;
  assign mem_data = dram[addr_q];

  dram_uart_transmitter #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (16),
    .START_ADDR   (SA),
    .NUM_BYTES    (16'(NB))
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .begin_transmit   (begin_transmit),
    .mem_data         (mem_data),
    .mem_addr         (mem_addr),
    .tx_active        (tx_active),
    .data_to_pc       (data_to_pc),
    .end_transmitting (end_transmitting)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Expected line level at bit position p of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return d[p-1];
`ifdef UART_TX_PARITY_EN
    if (p == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Counts negedges until the line goes low (bounded).
  task automatic wait_start(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (data_to_pc !== 1'b0 && lat < 50);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NB; i++) dram[16'(SA + i)] = 8'($urandom);
  endtask

  // Follows one complete run from the request to the first DONE cycle.
  task automatic check_run(input bit drop_early, input string name);
    int         lat;
    int         errs;
    logic [7:0] d;
    logic [7:0] got;
    wait_start(lat);
    check($sformatf("%s/start_latency", name), lat, START_LAT);
    if (drop_early) begin_transmit = 1'b0;
    for (int b = 0; b < NB; b++) begin
      d = dram[16'(SA + b)];
      check($sformatf("%s/b%0d/mem_addr", name, b), mem_addr, 16'(SA + b));
      errs = 0;
      got  = '0;
      for (int p = 0; p < BPF; p++) begin
        for (int c = 0; c < CPB; c++) begin
          if (data_to_pc !== exp_bit(d, p)) errs++;
          if (tx_active !== 1'b1 || end_transmitting !== 1'b0) errs++;
          if (c == CPB / 2 && p >= 1 && p <= 8) got[p-1] = data_to_pc;
          @(negedge clk);
        end
      end
      check($sformatf("%s/b%0d/frame_wave", name, b), errs, 0);
      check($sformatf("%s/b%0d/byte", name, b), got, d);
      if (b < NB - 1) begin
        errs = 0;
        for (int g = 0; g < GAP; g++) begin
          if (data_to_pc !== 1'b1 || tx_active !== 1'b1) errs++;
          @(negedge clk);
        end
        check($sformatf("%s/b%0d/gap", name, b), errs, 0);
      end else begin
        check($sformatf("%s/next_end", name), end_transmitting, 1'b0);
        check($sformatf("%s/next_line", name), data_to_pc, 1'b1);
        @(negedge clk);
        check($sformatf("%s/done_end", name), end_transmitting, 1'b1);
        check($sformatf("%s/done_active", name), tx_active, 1'b0);
        check($sformatf("%s/done_line", name), data_to_pc, 1'b1);
      end
    end
  endtask

  initial begin
    int lat;
    int errs;
    int lows;
    int ends;

    // NOTE: inputs are driven with blocking assignments at the negedge so
    // the DUT sees them settled well before the next posedge.
    rst            = 1'b1;
    begin_transmit = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/line", data_to_pc, 1'b1);
    check("reset/tx_active", tx_active, 1'b0);
    check("reset/end", end_transmitting, 1'b0);
    check("reset/mem_addr", mem_addr, SA);
    rst = 1'b0;

    errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (data_to_pc !== 1'b1 || tx_active !== 1'b0) errs++;
    end
    check("idle/quiet", errs, 0);

    // Run 1: fixed patterns, request held high through DONE.
    dram[16'(SA + 0)] = 8'hA5;
    dram[16'(SA + 1)] = 8'h01;
    dram[16'(SA + 2)] = 8'h80;
    begin_transmit = 1'b1;
    check_run(1'b0, "run1");

    lows = 0;
    ends = 0;
    repeat (100) begin
      @(negedge clk);
      if (data_to_pc !== 1'b1) lows++;
      if (end_transmitting !== 1'b1) ends++;
    end
    check("held/no_restart", lows, 0);
    check("held/end_stays", ends, 0);
    begin_transmit = 1'b0;
    @(negedge clk);
    check("release/end", end_transmitting, 1'b0);
    check("release/tx_active", tx_active, 1'b0);
    repeat (5) @(negedge clk);

    // Run 2: reassert after release, parity-sensitive patterns.
    dram[16'(SA + 0)] = 8'hFF;
    dram[16'(SA + 1)] = 8'h07;
    dram[16'(SA + 2)] = 8'h03;
    begin_transmit = 1'b1;
    check_run(1'b0, "run2");
    begin_transmit = 1'b0;
    @(negedge clk);
    check("run2/release_end", end_transmitting, 1'b0);

    // Run 3: request dropped right after the first start bit.
    fill_random();
    repeat (3) @(negedge clk);
    begin_transmit = 1'b1;
    check_run(1'b1, "run3_drop");
    @(negedge clk);
    check("run3_drop/idle_end", end_transmitting, 1'b0);

    // Reset during data bit 4 of the second byte.
    fill_random();
    dram[16'(SA + 1)] = 8'h00;
    repeat (2) @(negedge clk);
    begin_transmit = 1'b1;
    wait_start(lat);
    check("rst/start_latency", lat, START_LAT);
    repeat (BPF * CPB + GAP + 5 * CPB + 1) @(negedge clk);
    check("rst/pre_bit4_low", data_to_pc, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst/line_high", data_to_pc, 1'b1);
    check("rst/tx_active", tx_active, 1'b0);
    check("rst/end", end_transmitting, 1'b0);
    check("rst/mem_addr", mem_addr, SA);
    rst = 1'b0;
    fill_random();
    check_run(1'b0, "rst_restart");
    begin_transmit = 1'b0;
    @(negedge clk);

    // Randomised runs.
    for (int r = 0; r < 3; r++) begin
      fill_random();
      repeat ($urandom_range(1, 10)) @(negedge clk);
      begin_transmit = 1'b1;
      check_run(1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
      begin_transmit = 1'b0;
      @(negedge clk);
      check($sformatf("rand%0d/release_end", r), end_transmitting, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_uart_transmitter.md
Name: dram_uart_transmitter

Overview:
Downstream stage of the matrix processor. After a process run finishes, it reads a fixed window of result bytes from data memory (DRAM, 8-bit q) and serialises them to the PC over an 8N1 UART line. The top-level debounced begin_transmit starts it, and it reports completion to main_control via end_transmitting. It drives the DRAM address port while the processor is idle (status-muxed at top level).

Parameters:
CLKS_PER_BIT, 434, divided-clock cycles per UART bit (unsigned, at least 2)
ADDR_W, 16, data-memory address width
START_ADDR, 16'd0, first DRAM address transmitted
NUM_BYTES, 16'd9, bytes sent per run (at least 1)

Ports:
clk  input  1  divided system clock (clock_divider output)
rst  input  1  synchronous, active-high reset
begin_transmit  input  1  debounced level request; run starts while high in IDLE
mem_data  input  8  DRAM q
mem_addr  output  ADDR_W  DRAM read address
tx_active  output  1  high while the block owns the DRAM address port
data_to_pc  output  1  UART TX line, idle high
end_transmitting  output  1  high in DONE

Behaviour:
- Reset values (rst sampled on posedge clk): state=IDLE, data_to_pc=1, mem_addr=START_ADDR, tx_active=0, end_transmitting=0, bit counter=0, baud counter=0, byte counter=0.
- DRAM read latency: q is valid 2 cycles after mem_addr changes (registered address, then output). FETCH therefore waits exactly 2 cycles.
- States:
  - IDLE: if begin_transmit=1, set mem_addr=START_ADDR and byte_cnt=0, tx_active=1, go to FETCH.
  - FETCH: 2-cycle wait, then latch mem_data into shift_reg and go to START.
  - START: data_to_pc=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive 8 bits LSB first, each held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: data_to_pc=1 for CLKS_PER_BIT cycles, then go to NEXT.
  - NEXT (1 cycle): if byte_cnt==NUM_BYTES-1, go to DONE. Otherwise byte_cnt+1, mem_addr+1, go to FETCH.
  - DONE: end_transmitting=1, tx_active=0, data_to_pc=1. Stay in DONE while begin_transmit=1; return to IDLE when it is 0. This prevents retransmission from a held switch.
- Frame length: exactly 10*CLKS_PER_BIT cycles per byte. The inter-byte gap is 3 cycles (NEXT plus 2 FETCH), with the line high.
- Counters:
  - baud_cnt counts 0..CLKS_PER_BIT-1 and resets on every bit boundary.
  - mem_addr increments modulo 2^ADDR_W; wrap from 16'hFFFF to 0 is legal and not flagged.
- begin_transmit dropping mid-run is ignored; the run completes.
- rst mid-frame: the line returns high on the next cycle and the partial frame is abandoned, with no stop bit inserted.
- mem_data is sampled only on the last FETCH cycle and is ignored at all other times.
- data_to_pc is driven from a flop (glitch-free).

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined: a PARITY state sits between DATA and STOP and drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. The frame becomes 11*CLKS_PER_BIT cycles.
- When undefined: no PARITY state, 8N1 framing, 10 bit periods per frame.

Decomposition:
- Shared package uart_pkg:
  - state encoding enum (IDLE, FETCH, START, DATA, PARITY, STOP, NEXT, DONE)
  - constants UART_DATA_BITS=8, DRAM_READ_LATENCY=2, UART_IDLE_LEVEL=1'b1
- One natural sub-module: uart_baud_tick. It is a CLKS_PER_BIT counter with synchronous clear that emits a 1-cycle tick at count CLKS_PER_BIT-1. The FSM and shift register stay in the top of the block.

Test Plan:
- CLKS_PER_BIT=4, NUM_BYTES=1, DRAM[0]=8'hA5, begin_transmit held high. Expected line sequence: start 0, then bits 1,0,1,0,0,1,0,1, then stop 1, each held 4 cycles. end_transmitting rises 1 cycle after the stop bit ends.
- NUM_BYTES=3, DRAM[0..2]=8'h01,8'h80,8'hFF. Expected: three frames decoded by a bench UART monitor as 01,80,FF, separated by 3-cycle gaps. mem_addr steps 0→1→2.
- After DONE, keep begin_transmit=1 for 100 cycles: no new start bit. Drop it, then reassert: a new run starts at START_ADDR.
- Assert rst during bit 4 of byte 2: next cycle data_to_pc=1, tx_active=0, end_transmitting=0, state IDLE. Deassert rst with begin_transmit high: the run restarts from byte 0.
- START_ADDR=16'hFFFF, NUM_BYTES=2: bytes are read from FFFF, then 0000 (wrap).
- With UART_TX_PARITY_EN, data 8'h07: parity bit=1 and frame length=44 cycles at CLKS_PER_BIT=4. Data 8'h03 gives parity=0.
